// File: rtl/des_decrypt_key_sched.sv
// Iterative DES decryption key scheduler: emits K16..K1 from a post-PC-1 key,
// one round key per valid/ready handshake, rotating the C and D halves right.

// PC-2 permutation: pure wiring from the 56-bit C||D register to a 48-bit round key.
module p_box_56_48 (
   input  logic [55:0] din,
   output logic [47:0] dout
);
   assign dout = {din[42], din[39], din[45], din[32], din[55], din[51],
                  din[53], din[28], din[41], din[50], din[35], din[46],
                  din[33], din[37], din[44], din[52], din[30], din[48],
                  din[40], din[49], din[29], din[36], din[43], din[54],
                  din[15], din[4],  din[25], din[19], din[9],  din[1],
                  din[26], din[16], din[5],  din[11], din[23], din[8],
                  din[12], din[7],  din[17], din[0],  din[22], din[3],
                  din[10], din[14], din[6],  din[20], din[27], din[24]};
endmodule

// Handshake: rk_out/rk_index are transferred on a clock edge where rk_valid and
// rk_ready are both high; while rk_ready is low everything is held unchanged.
module des_decrypt_key_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [55:0] key_in,
   output logic        busy,
   output logic        rk_valid,
   input  logic        rk_ready,
   output logic [47:0] rk_out,
   output logic [3:0]  rk_index,
   output logic        done
);
   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t      state, state_next;
   logic [55:0] cd_reg, cd_next;
   logic [3:0]  step, step_next, step_inc;
   logic        done_next;

   // Right-shift amount applied when moving into a given step; step 0 is unrotated.
   function automatic logic [1:0] shift_amt(input logic [3:0] s);
      case (s)
         4'd0:               return 2'd0;
         4'd1, 4'd8, 4'd15:  return 2'd1;
         default:            return 2'd2;
      endcase
   endfunction

   function automatic logic [27:0] ror_half(input logic [27:0] x, input logic [1:0] a);
      case (a)
         2'd1:    return {x[0], x[27:1]};
         2'd2:    return {x[1:0], x[27:2]};
         default: return x;
      endcase
   endfunction

   always_comb begin
      state_next = state;
      cd_next    = cd_reg;
      step_next  = step;
      done_next  = 1'b0;
      step_inc   = step + 4'd1;
      case (state)
         IDLE: begin
            if (start) begin
               cd_next    = key_in;
               step_next  = 4'd0;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (step == 4'd15) begin
                  state_next = IDLE;
                  done_next  = 1'b1;
               end else begin
                  cd_next   = {ror_half(cd_reg[55:28], shift_amt(step_inc)),
                               ror_half(cd_reg[27:0],  shift_amt(step_inc))};
                  step_next = step_inc;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cd_reg <= 56'h0;
         step   <= 4'd0;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         cd_reg <= cd_next;
         step   <= step_next;
         done   <= done_next;
      end
   end

   assign busy     = (state == EMIT);
   assign rk_valid = (state == EMIT);
   assign rk_index = (state == EMIT) ? (4'd15 - step) : 4'd0;

   p_box_56_48 u_pc2 (
      .din  (cd_reg),
      .dout (rk_out)
   );
endmodule

// File: tb/tb_des_decrypt_key_sched.sv
// Bench for des_decrypt_key_sched: compares emitted keys with a left-rotate
// encryption-side key schedule model, reversed.
module tb_des_decrypt_key_sched;
   logic        clk;
   logic        rst;
   logic        start;
   logic [55:0] key_in;
   logic        busy;
   logic        rk_valid;
   logic        rk_ready;
   logic [47:0] rk_out;
   logic [3:0]  rk_index;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [47:0] exp_q[$];

   localparam logic [55:0] STD_KEY = 56'hF0CCAAF556678F;

   int pc2_tab[48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                       23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                       41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                       44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   int sh_tab[16]  = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_decrypt_key_sched dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_out   (rk_out),
      .rk_index (rk_index),
      .done     (done)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   // Reference model: FIPS 46 bit numbering, bit 1 is the MSB.
   function automatic logic [47:0] pc2_model(input logic [55:0] cd);
      logic [47:0] r;
      for (int j = 0; j < 48; j++) r[47-j] = cd[56 - pc2_tab[j]];
      return r;
   endfunction

   function automatic logic [55:0] rand56();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[55:0];
   endfunction

   // Encryption-side K1..K16 by cumulative left rotation, queued in reverse.
   task automatic build_dec_keys(input logic [55:0] key);
      logic [27:0] c, d;
      logic [47:0] enc[16];
      c = key[55:28];
      d = key[27:0];
      for (int i = 0; i < 16; i++) begin
         c = (c << sh_tab[i]) | (c >> (28 - sh_tab[i]));
         d = (d << sh_tab[i]) | (d >> (28 - sh_tab[i]));
         enc[i] = pc2_model({c, d});
      end
      exp_q.delete();
      for (int i = 15; i >= 0; i--) exp_q.push_back(enc[i]);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; key_in = 56'h0; rk_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rk_valid); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (rk_index !== 4'd0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", rk_index); end
      n_checks++; if (rk_out !== 48'h0) begin n_fail++; $display("FAIL reset_rk_out: got %h want 0", rk_out); end
      rst = 1'b0;
   endtask

   task automatic test_standard();
      logic [47:0] exp;
      build_dec_keys(STD_KEY);
      @(negedge clk);
      rk_ready = 1'b1; start = 1'b1; key_in = STD_KEY;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start = 1'b0; key_in = rand56();
         exp = exp_q.pop_front();
         n_checks++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL std_valid c%0d: got %b want 1", c, rk_valid); end
         n_checks++; if (rk_out !== exp) begin n_fail++; $display("FAIL std_key c%0d: got %h want %h", c, rk_out, exp); end
         n_checks++; if (rk_index !== 4'(16 - c)) begin n_fail++; $display("FAIL std_index c%0d: got %0d want %0d", c, rk_index, 16 - c); end
         if (c == 1) begin
            n_checks++; if (rk_out !== 48'hCB3D8B0E17F5) begin n_fail++; $display("FAIL std_k16: got %h want cb3d8b0e17f5", rk_out); end
         end
         if (c == 2) begin
            n_checks++; if (rk_out !== 48'hBF918D3D3F0A) begin n_fail++; $display("FAIL std_k15: got %h want bf918d3d3f0a", rk_out); end
         end
         if (c == 16) begin
            n_checks++; if (rk_out !== 48'h1B02EFFC7072) begin n_fail++; $display("FAIL std_k1: got %h want 1b02effc7072", rk_out); end
         end
      end
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL std_done: got %b want 1", done); end
      n_checks++; if ({busy, rk_valid} !== 2'b00) begin n_fail++; $display("FAIL std_idle: busy/valid got %b want 00", {busy, rk_valid}); end
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL std_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_backpressure();
      logic [47:0] exp, held_out;
      logic [3:0]  held_idx;
      logic        held_valid;
      int          accepted, cyc;
      logic        seen_done;
      build_dec_keys(STD_KEY);
      rk_ready = 1'b0; start = 1'b1; key_in = STD_KEY;
      @(negedge clk);
      start = 1'b0;
      held_valid = 1'b0; accepted = 0; cyc = 0; seen_done = 1'b0;
      while (!seen_done && cyc < 300) begin
         if (done === 1'b1) begin
            seen_done = 1'b1;
         end else begin
            n_checks++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc%0d: got %b want 1", cyc, rk_valid); end
            if (held_valid) begin
               n_checks++;
               if ({rk_out, rk_index} !== {held_out, held_idx}) begin
                  n_fail++; $display("FAIL bp_hold cyc%0d: got %h/%0d want %h/%0d", cyc, rk_out, rk_index, held_out, held_idx);
               end
            end
            rk_ready = 1'($urandom_range(0, 1));
            if (rk_valid && rk_ready) begin
               exp = exp_q.pop_front();
               n_checks++; if (rk_out !== exp) begin n_fail++; $display("FAIL bp_key #%0d: got %h want %h", accepted, rk_out, exp); end
               n_checks++; if (rk_index !== 4'(15 - accepted)) begin n_fail++; $display("FAIL bp_index #%0d: got %0d want %0d", accepted, rk_index, 15 - accepted); end
               accepted++;
               held_valid = 1'b0;
            end else begin
               held_valid = rk_valid; held_out = rk_out; held_idx = rk_index;
            end
            @(negedge clk);
            cyc++;
         end
      end
      n_checks++; if (!seen_done) begin n_fail++; $display("FAIL bp_timeout: done not seen after %0d cycles", cyc); end
      n_checks++; if (accepted != 16) begin n_fail++; $display("FAIL bp_count: got %0d keys want 16", accepted); end
      rk_ready = 1'b1;
   endtask

   task automatic test_cross_check();
      logic [55:0] key;
      logic [47:0] exp;
      for (int k = 0; k < 20; k++) begin
         key = rand56();
         build_dec_keys(key);
         @(negedge clk);
         rk_ready = 1'b1; start = 1'b1; key_in = key;
         for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp = exp_q.pop_front();
            n_checks++; if (rk_out !== exp) begin n_fail++; $display("FAIL xchk_key k%0d c%0d: got %h want %h", k, c, rk_out, exp); end
         end
         @(negedge clk);
         n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL xchk_done k%0d: got %b want 1", k, done); end
      end
   endtask

   task automatic test_start_while_busy();
      logic [55:0] key_a, key_b;
      logic [47:0] exp;
      int done_cnt;
      key_a = rand56();
      key_b = key_a ^ 56'h0F0F0F0F0F0F0F;
      build_dec_keys(key_a);
      done_cnt = 0;
      @(negedge clk);
      rk_ready = 1'b1; start = 1'b1; key_in = key_a;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         key_in = key_b;
         if (done === 1'b1) done_cnt++;
         exp = exp_q.pop_front();
         n_checks++; if (rk_out !== exp) begin n_fail++; $display("FAIL swb_key c%0d: got %h want %h", c, rk_out, exp); end
         n_checks++; if (rk_index !== 4'(16 - c)) begin n_fail++; $display("FAIL swb_index c%0d: got %0d want %0d", c, rk_index, 16 - c); end
         start = (c == 3) || (c == 16);
      end
      for (int c = 17; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) done_cnt++;
         n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL swb_idle c%0d: rk_valid got %b want 0", c, rk_valid); end
      end
      n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL swb_done_count: got %0d want 1", done_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [55:0] key;
      logic [47:0] exp;
      key = rand56();
      build_dec_keys(key);
      @(negedge clk);
      rk_ready = 1'b1; start = 1'b1; key_in = key;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start = 1'b0;
         exp = exp_q.pop_front();
         n_checks++; if (rk_out !== exp) begin n_fail++; $display("FAIL rm_key c%0d: got %h want %h", c, rk_out, exp); end
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if ({rk_valid, busy, done} !== 3'b000) begin n_fail++; $display("FAIL rm_flags: valid/busy/done got %b want 000", {rk_valid, busy, done}); end
      n_checks++; if (rk_out !== 48'h0) begin n_fail++; $display("FAIL rm_rk_out: got %h want 0", rk_out); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if ({rk_valid, done} !== 2'b00) begin n_fail++; $display("FAIL rm_quiet c%0d: valid/done got %b want 00", c, {rk_valid, done}); end
      end
      key = rand56();
      build_dec_keys(key);
      start = 1'b1; key_in = key;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start = 1'b0;
         exp = exp_q.pop_front();
         n_checks++; if (rk_out !== exp) begin n_fail++; $display("FAIL rm_restart_key c%0d: got %h want %h", c, rk_out, exp); end
         if (c == 1) begin
            n_checks++; if (rk_index !== 4'd15) begin n_fail++; $display("FAIL rm_restart_index: got %0d want 15", rk_index); end
         end
      end
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rm_restart_done: got %b want 1", done); end
   endtask

   task automatic test_back_to_back();
      logic [55:0] key_a, key_b;
      logic [47:0] exp;
      key_a = rand56();
      key_b = rand56();
      build_dec_keys(key_a);
      @(negedge clk);
      rk_ready = 1'b1; start = 1'b1; key_in = key_a;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start = 1'b0;
         exp = exp_q.pop_front();
         n_checks++; if (rk_out !== exp) begin n_fail++; $display("FAIL b2b_a_key c%0d: got %h want %h", c, rk_out, exp); end
      end
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
      build_dec_keys(key_b);
      start = 1'b1; key_in = key_b;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         start = 1'b0;
         exp = exp_q.pop_front();
         n_checks++; if (rk_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid c%0d: got %b want 1", c, rk_valid); end
         n_checks++; if (rk_out !== exp) begin n_fail++; $display("FAIL b2b_b_key c%0d: got %h want %h", c, rk_out, exp); end
         n_checks++; if (rk_index !== 4'(16 - c)) begin n_fail++; $display("FAIL b2b_index c%0d: got %0d want %0d", c, rk_index, 16 - c); end
      end
      @(negedge clk);
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b want 1", done); end
   endtask

   initial begin
      test_reset();
      test_standard();
      test_backpressure();
      test_cross_check();
      test_start_while_busy();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
